// File: rtl/lora_rx_interface_if.sv
// SPI link between the LoRa receive sequencer (master) and the SX1278 radio (slave).
interface lora_rx_interface_if;
    logic spi_miso;
    logic spi_cs_l;
    logic spi_sclk;
    logic spi_mosi;

    modport master (
        input  spi_miso,
        output spi_cs_l,
        output spi_sclk,
        output spi_mosi
    );

    modport slave (
        output spi_miso,
        input  spi_cs_l,
        input  spi_sclk,
        input  spi_mosi
    );
endinterface

// File: rtl/lora_rx_interface.sv
// SX1278 LoRa receive sequencer: configures RX-continuous mode over SPI, polls IRQ
// flags and delivers each CRC-good payload byte on rx_data with a one-cycle rx_valid.
module lora_rx_interface (
    input  logic                       clk_in,
    input  logic                       rst,
    lora_rx_interface_if.master        spi,
    output logic [7:0]                 rx_data,
    output logic                       rx_valid,
    output logic                       VRx,
    output logic                       VRy,
    output logic                       SW,
    output logic                       btn1,
    output logic                       btn2,
    output logic                       btn3,
    output logic                       btn4,
    output logic                       rmt_rst,
    output logic [7:0]                 crc_err_cnt,
    output logic                       init_done,
    output logic [3:0]                 _state
);

    typedef enum logic [3:0] {
        INIT0   = 4'd0,
        INIT1   = 4'd1,
        INIT2   = 4'd2,
        INIT3   = 4'd3,
        POLL    = 4'd4,
        CHK     = 4'd5,
        CLR_ERR = 4'd6,
        RD_CUR  = 4'd7,
        SET_PTR = 4'd8,
        RD_FIFO = 4'd9,
        CLR_OK  = 4'd10,
        GAP     = 4'd11
    } state_t;

    // Frame slot counter: 0 setup, 1..32 bit cells (odd sclk=0, even sclk=1),
    // 33 CS hold, 34..35 CS high. Frame states own slots 0..33, CHK/GAP own 34..35.
    localparam logic [5:0] CNT_LAST_BIT = 6'd32;
    localparam logic [5:0] CNT_HOLD     = 6'd33;
    localparam logic [5:0] CNT_GAP0     = 6'd34;
    localparam logic [5:0] CNT_END      = 6'd35;

    state_t      state, state_nxt;
    state_t      ret_state, ret_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [7:0]  rd_shift;
    logic [7:0]  ptr;
    logic        frame_end;
    logic        in_bits;
    logic [3:0]  bit_idx;
    logic [15:0] word_nxt;

    function automatic logic [15:0] frame_word(input state_t s, input logic [7:0] p);
        case (s)
            INIT0:   frame_word = 16'h8181;
            INIT1:   frame_word = 16'h8F00;
            INIT2:   frame_word = 16'h8D00;
            INIT3:   frame_word = 16'h8185;
            POLL:    frame_word = 16'h1200;
            CLR_ERR: frame_word = 16'h92FF;
            RD_CUR:  frame_word = 16'h1000;
            SET_PTR: frame_word = {8'h8D, p};
            RD_FIFO: frame_word = 16'h0000;
            CLR_OK:  frame_word = 16'h92FF;
            default: frame_word = 16'h0000;
        endcase
    endfunction

    function automatic state_t follow_state(input state_t s);
        case (s)
            INIT0:   follow_state = INIT1;
            INIT1:   follow_state = INIT2;
            INIT2:   follow_state = INIT3;
            RD_CUR:  follow_state = SET_PTR;
            SET_PTR: follow_state = RD_FIFO;
            RD_FIFO: follow_state = CLR_OK;
            default: follow_state = POLL;
        endcase
    endfunction

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= INIT0;
            ret_state <= INIT0;
            cnt       <= CNT_END;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        cnt_nxt   = (cnt == CNT_END) ? 6'd0 : cnt + 6'd1;
        frame_end = 1'b0;
        case (state)
            INIT0, INIT1, INIT2, INIT3, POLL, CLR_ERR, RD_CUR, SET_PTR, RD_FIFO, CLR_OK: begin
                if (cnt == CNT_HOLD) begin
                    frame_end = 1'b1;
                    state_nxt = (state == POLL) ? CHK : GAP;
                    ret_nxt   = follow_state(state);
                end
            end
            CHK: begin
                if (cnt == CNT_END) begin
                    if (!rd_shift[6])
                        state_nxt = POLL;
                    else if (rd_shift[5])
                        state_nxt = CLR_ERR;
                    else
                        state_nxt = RD_CUR;
                end
            end
            GAP: begin
                if (cnt == CNT_END)
                    state_nxt = ret_state;
            end
            default: begin
                state_nxt = INIT0;
                cnt_nxt   = CNT_END;
            end
        endcase
    end

    assign in_bits  = (cnt_nxt >= 6'd1) && (cnt_nxt <= CNT_LAST_BIT);
    assign bit_idx  = 4'd15 - 4'((cnt_nxt - 6'd1) >> 1);
    assign word_nxt = frame_word(state_nxt, ptr);

    // rx_valid is a one-cycle strobe with no back-pressure: rx_data is valid and
    // newly updated exactly in the cycle rx_valid is high, and holds until the next.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            spi.spi_cs_l <= 1'b1;
            spi.spi_sclk <= 1'b0;
            spi.spi_mosi <= 1'b0;
            rd_shift     <= 8'h00;
            ptr          <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            crc_err_cnt  <= 8'h00;
            init_done    <= 1'b0;
        end else begin
            spi.spi_cs_l <= (cnt_nxt >= CNT_GAP0);
            spi.spi_sclk <= in_bits && !cnt_nxt[0];
            spi.spi_mosi <= in_bits ? word_nxt[bit_idx] : 1'b0;
            // Sample on the edge that raises sclk, i.e. at the end of an odd slot.
            if (cnt[0] && (cnt <= 6'd31))
                rd_shift <= {rd_shift[6:0], spi.spi_miso};
            rx_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    INIT3:   init_done <= 1'b1;
                    RD_CUR:  ptr <= rd_shift;
                    RD_FIFO: begin
                        rx_data  <= rd_shift;
                        rx_valid <= 1'b1;
                    end
                    CLR_ERR: begin
                        if (crc_err_cnt != 8'hFF)
                            crc_err_cnt <= crc_err_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign {VRx, VRy, SW, btn1, btn2, btn3, btn4, rmt_rst} = rx_data;
    assign _state = state;

endmodule

// File: tb/tb_lora_rx_interface.sv
// Directed bench for lora_rx_interface with a small SX1278 register model on the SPI link.
module tb_lora_rx_interface;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       VRx, VRy, SW, btn1, btn2, btn3, btn4, rmt_rst;
    logic [7:0] crc_err_cnt;
    logic       init_done;
    logic [3:0] dbg_state;

    lora_rx_interface_if spi ();

    lora_rx_interface dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .spi         (spi),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .VRx         (VRx),
        .VRy         (VRy),
        .SW          (SW),
        .btn1        (btn1),
        .btn2        (btn2),
        .btn3        (btn3),
        .btn4        (btn4),
        .rmt_rst     (rmt_rst),
        .crc_err_cnt (crc_err_cnt),
        .init_done   (init_done),
        ._state      (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // SX1278 register model
    logic [7:0]  irq_val  = 8'h00;
    logic [7:0]  cur_val  = 8'h05;
    logic [7:0]  fifo_val = 8'hA6;
    bit          auto_err = 1'b0;
    int          bitcnt   = 0;
    logic [15:0] cap      = 16'h0000;
    logic [7:0]  resp     = 8'h00;
    logic [15:0] obs_q[$];
    int          clr_frames = 0;
    int          valid_cnt  = 0;
    int          cyc        = 0;
    int          last_fall  = 0;
    int          period     = 0;

    function automatic logic [7:0] reg_read(input logic [6:0] addr);
        case (addr)
            7'h12:   reg_read = irq_val;
            7'h10:   reg_read = cur_val;
            7'h00:   reg_read = fifo_val;
            default: reg_read = 8'h00;
        endcase
    endfunction

    always @(posedge clk_in) begin
        cyc++;
        if (rx_valid) valid_cnt++;
    end

    always @(negedge spi.spi_cs_l) begin
        bitcnt    = 0;
        cap       = 16'h0000;
        period    = cyc - last_fall;
        last_fall = cyc;
    end

    always @(posedge spi.spi_sclk) begin
        cap = {cap[14:0], spi.spi_mosi};
        bitcnt++;
    end

    always @(negedge spi.spi_sclk) begin
        #1;
        if (bitcnt == 8) resp = cap[7] ? 8'h00 : reg_read(cap[6:0]);
        if (bitcnt >= 8 && bitcnt < 16) spi.spi_miso = resp[3'(15 - bitcnt)];
        else spi.spi_miso = 1'b0;
    end

    always @(posedge spi.spi_cs_l) begin
        if (bitcnt == 16) begin
            obs_q.push_back(cap);
            if (cap == 16'h92FF) begin
                clr_frames++;
                if (!auto_err) irq_val = 8'h00;
            end
        end
        spi.spi_miso = 1'b0;
    end

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge clk_in);
            k++;
        end
        #1;
        check({tag, "_frames_seen"}, 32'(obs_q.size() >= n), 32'd1);
    endtask

    function automatic logic [15:0] pop_frame();
        if (obs_q.size() == 0) return 16'hxxxx;
        return obs_q.pop_front();
    endfunction

    task automatic sync_gap();
        @(posedge spi.spi_cs_l);
        #1;
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int target;
        int k;
        spi.spi_miso = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_cs_l", spi.spi_cs_l, 1);
        check("rst_sclk", spi.spi_sclk, 0);
        check("rst_mosi", spi.spi_mosi, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_crc_cnt", crc_err_cnt, 8'h00);
        check("rst_init_done", init_done, 0);
        check("rst_state", dbg_state, 4'd0);

        // Init sequence
        @(negedge clk_in) rst = 1'b0;
        wait_frames(4, 400, "init");
        check("init_f0", pop_frame(), 16'h8181);
        check("init_f1", pop_frame(), 16'h8F00);
        check("init_f2", pop_frame(), 16'h8D00);
        check("init_f3", pop_frame(), 16'h8185);
        check("init_done", init_done, 1);

        // Idle polling
        @(negedge spi.spi_cs_l);
        #1;
        check("poll_state", dbg_state, 4'd4);
        obs_q.delete();
        wait_frames(2, 200, "poll");
        check("poll_f0", pop_frame(), 16'h1200);
        check("poll_f1", pop_frame(), 16'h1200);
        check("poll_period", period, 36);

        // Good packet
        sync_gap();
        v0 = valid_cnt;
        irq_val = 8'h40;
        wait_frames(6, 600, "ok");
        check("ok_f0", pop_frame(), 16'h1200);
        check("ok_f1", pop_frame(), 16'h1000);
        check("ok_f2", pop_frame(), 16'h8D05);
        check("ok_f3", pop_frame(), 16'h0000);
        check("ok_f4", pop_frame(), 16'h92FF);
        check("ok_f5", pop_frame(), 16'h1200);
        check("ok_valid_pulses", valid_cnt - v0, 1);
        check("ok_rx_data", rx_data, 8'hA6);
        check("ok_fields", {VRx, VRy, SW, btn1, btn2, btn3, btn4, rmt_rst}, 8'hA6);
        check("ok_VRx", VRx, 1);
        check("ok_btn2", btn2, 0);
        check("ok_crc_cnt", crc_err_cnt, 8'h00);

        // CRC-error packet
        sync_gap();
        v0 = valid_cnt;
        irq_val = 8'h60;
        wait_frames(3, 300, "err");
        check("err_f0", pop_frame(), 16'h1200);
        check("err_f1", pop_frame(), 16'h92FF);
        check("err_f2", pop_frame(), 16'h1200);
        check("err_crc_cnt", crc_err_cnt, 8'h01);
        check("err_no_valid", valid_cnt - v0, 0);
        check("err_rx_hold", rx_data, 8'hA6);

        // Saturation over 260 consecutive CRC errors
        sync_gap();
        v0 = valid_cnt;
        target = clr_frames + 260;
        auto_err = 1'b1;
        irq_val = 8'h60;
        k = 0;
        while (clr_frames < target && k < 260 * 72 + 400) begin
            @(posedge clk_in);
            k++;
        end
        auto_err = 1'b0;
        irq_val = 8'h00;
        #1;
        check("sat_frames_seen", 32'(clr_frames >= target), 32'd1);
        check("sat_crc_cnt", crc_err_cnt, 8'hFF);
        check("sat_no_valid", valid_cnt - v0, 0);
        check("sat_rx_hold", rx_data, 8'hA6);

        // Reset during the FIFO-read frame
        sync_gap();
        v0 = valid_cnt;
        irq_val = 8'h40;
        k = 0;
        while (dbg_state != 4'd9 && k < 1000) begin
            @(posedge clk_in);
            k++;
        end
        check("abort_reached_fifo", dbg_state, 4'd9);
        k = 0;
        while (bitcnt < 7 && k < 100) begin
            @(posedge clk_in);
            k++;
        end
        @(negedge clk_in) rst = 1'b1;
        #1;
        check("abort_cs_l", spi.spi_cs_l, 1);
        check("abort_sclk", spi.spi_sclk, 0);
        check("abort_state", dbg_state, 4'd0);
        check("abort_rx_data", rx_data, 8'h00);
        check("abort_crc_cnt", crc_err_cnt, 8'h00);
        check("abort_init_done", init_done, 0);
        irq_val = 8'h00;
        repeat (3) @(posedge clk_in);
        obs_q.delete();
        @(negedge clk_in) rst = 1'b0;
        wait_frames(1, 100, "restart");
        check("restart_f0", pop_frame(), 16'h8181);
        check("abort_no_valid", valid_cnt - v0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lora_rx_interface.md
LORA_RX_INTERFACE -- requirements
Module: lora_rx_interface

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows:
- clk_in  in  1  system clock
- rst  in  1  asynchronous reset, active-high

REQ-002 The remaining ports SHALL be:
- spi_miso  in  1  serial data from SX1278
- spi_cs_l  out  1  active-low chip select to SX1278
- spi_sclk  out  1  SPI clock to SX1278, mode 0
- spi_mosi  out  1  serial data to SX1278
- rx_data  out  8  last good payload byte
- rx_valid  out  1  one-cycle strobe, rx_data updated
- VRx, VRy, SW, btn1, btn2, btn3, btn4, rmt_rst  out  1 each  rx_data bits 7..0, in that order
- crc_err_cnt  out  8  count of CRC-failed packets, saturating
- init_done  out  1  high once RX-continuous mode is entered
- _state  out  4  sequencer state, for debug only

Function
REQ-003 SPI frame SHALL be 16 bits, MSB first: {wnr, addr[6:0], data[7:0]}; wnr=1 for write, 0 for read.
REQ-004 Frame timing SHALL be:
- 1 clk with CS low, sclk low
- then per bit 2 clks: sclk=0 with mosi driven, then sclk=1
- miso sampled on the clk edge that raises sclk
- then 1 clk CS-hold with sclk low, then CS high for at least 2 clks
- total frame-to-frame period 36 clks
REQ-005 For reads, the last 8 sampled miso bits SHALL form the read byte, valid on the first CS-high cycle.
REQ-006 Init sequence SHALL run in this order: write 0x01=0x81 (LoRa standby), write 0x0F=0x00 (RX base), write 0x0D=0x00 (FIFO ptr), write 0x01=0x85 (RX continuous).
REQ-007 init_done SHALL go high on the first CS-high cycle after the last init frame and stay high until reset.
REQ-008 The poll loop SHALL read RegIrqFlags 0x12 repeatedly and branch as follows:
- bit6 RxDone=0: poll again
- RxDone=1 and bit5 PayloadCrcError=1: write 0x12=0xFF, increment crc_err_cnt (saturating at 0xFF), resume polling
- RxDone=1 and CRC ok: read 0x10, write 0x0D=<that value>, read 0x00 (FIFO), write 0x12=0xFF
REQ-009 In the CRC-ok path, rx_data and the 8 field outputs SHALL update, and rx_valid SHALL pulse for exactly one clk, on the first CS-high cycle after the FIFO read.
REQ-010 rx_data and the field outputs SHALL hold their values between packets.
REQ-011 The sequencer SHALL use states 0..11, with one state per frame plus a wait state:
- INIT0-3 = 0-3
- POLL = 4
- CHK = 5
- CLR_ERR = 6
- RD_CUR = 7
- SET_PTR = 8
- RD_FIFO = 9
- CLR_OK = 10
- GAP = 11
_state SHALL equal the current state.
REQ-012 A new frame SHALL NOT start while the previous frame is in progress, including its CS-high gap.
REQ-013 Unused state encodings SHALL return to INIT0 on the next clk.
REQ-014 spi_mosi SHALL be 0 and spi_sclk SHALL be 0 whenever spi_cs_l is high.

Reset
REQ-015 Asserting rst at any time, including mid-frame, SHALL immediately force:
- spi_cs_l=1, spi_sclk=0, spi_mosi=0
- rx_data=0x00 and all field outputs 0
- rx_valid=0, crc_err_cnt=0, init_done=0
- _state=0
REQ-016 After rst deasserts, the init sequence SHALL restart from INIT0 on the first clk edge.

Verification
REQ-017 Reset then idle miso=0 -> MOSI frames 0x8181, 0x8F00, 0x8D00, 0x8185 in order; init_done=1; then repeated 0x1200 polls every 36 clks.
REQ-018 SX1278 model returns IrqFlags 0x40, RegFifoRxCurrentAddr 0x05, FIFO byte 0xA6 -> frames 0x1000, 0x8D05, 0x0000, 0x92FF; rx_valid pulses once; rx_data=0xA6; VRx=1, VRy=0, SW=1, btn1=0, btn2=0, btn3=1, btn4=1, rmt_rst=0.
REQ-019 IrqFlags 0x60 -> frame 0x92FF; crc_err_cnt 0->1; no rx_valid; rx_data unchanged.
REQ-020 260 consecutive CRC-error packets -> crc_err_cnt saturates at 0xFF.
REQ-021 rst pulsed during bit 7 of the FIFO-read frame -> spi_cs_l=1 in the same cycle; no rx_valid; init frames restart with 0x8181.
